tmds_decoder_dvi_rx: RTL and testbench
======================================

Name: tmds_decoder_dvi_rx

Overview:
Receive-side counterpart of the DVI TMDS encoder for one channel. Takes unaligned 10-bit words from an external 1:10 deserializer, one word per pixel clock, with bit 0 received first. Finds the word boundary by hunting for TMDS control tokens, then decodes each word to 8-bit data or 2-bit control plus a display-enable flag. One instance per colour channel, sitting between the deserializer and the display timing recovery logic.

Parameters:
LOCK_COUNT, 16, consecutive aligned control tokens needed to declare lock
SLIP_CYCLES, 1024, cycles spent at one bit offset in HUNT before advancing the offset
LOSS_CYCLES, 4096, cycles in LOCKED with no control token before returning to HUNT

Ports:
i_clk  input  1  pixel clock
i_rst_n  input  1  asynchronous reset, active low
i_clk_lock  input  1  upstream clock/deserializer locked (active high)
i_tmds  input  10  raw deserialized word, bit 0 earliest, arbitrary bit alignment
o_de  output  1  decoded display enable (1 = data word)
o_data  output  8  decoded pixel data
o_ctrl  output  2  decoded control bits {C1,C0}
o_locked  output  1  word alignment locked
o_offset  output  4  current bit offset, 0..9

Behaviour:
- Reset, asserted asynchronously: state HUNT, offset 0, all counters 0, prev word 0, all outputs 0.
- i_clk_lock low acts as a synchronous return to the reset state; the outputs are also 0 on that edge.
- Window: prev <= i_tmds each cycle. w = {i_tmds, prev} (20 bits). The aligned word is w[offset+9:offset].
- Pipeline stage 1 registers the aligned word (aw). Stage 2 registers the decoded outputs. Latency from i_tmds to outputs is 2 cycles after the word is complete in the window.
- Token test on aw ([9:0]):
  - 10'b1101010100 -> ctrl 00
  - 10'b0010101011 -> ctrl 01
  - 10'b0101010100 -> ctrl 10
  - 10'b1010101011 -> ctrl 11
- Data decode of aw:
  - q = aw[9] ? ~aw[7:0] : aw[7:0]
  - data[0] = q[0]
  - for i = 1..7: data[i] = aw[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1])
- HUNT state:
  - run counter: +1 when aw is a token, cleared otherwise.
  - slip counter: +1 every cycle.
  - run reaches LOCK_COUNT -> LOCKED; clear slip counter.
  - slip counter reaches SLIP_CYCLES-1 without lock -> offset += 1 (9 wraps to 0); clear run and slip counters.
  - If lock and slip expiry happen on the same cycle, lock wins and the offset is unchanged.
  - Outputs in HUNT: o_de=0, o_data=0, o_ctrl=0, o_locked=0.
- LOCKED state:
  - o_locked=1.
  - Token word: o_de=0, o_ctrl=decoded value, o_data=0.
  - Non-token word: o_de=1, o_data=decoded value, o_ctrl holds its last value.
  - loss counter: cleared on every token, +1 otherwise.
  - Loss counter reaches LOSS_CYCLES-1 -> HUNT with offset += 1 (wrapping); clear counters; o_locked falls on the same edge.
- o_locked and o_offset are registered and consistent with the stage-2 outputs.
- Counter widths are $clog2 of their limit plus 1; counters saturate and never wrap.
- Invalid 10-bit words are not flagged; they are decoded as data.

Decomposition:
- Shared package (tmds_pkg, also used by the encoder): the four control token constants, state encoding (HUNT, LOCKED), and data/control width constants.
- One natural sub-module: tmds_decode_word, a combinational 10->8 data decode plus token detect/ctrl decode, instantiated once at stage 2.

Test Plan:
- Reset: i_rst_n=0 mid-stream while LOCKED -> all outputs 0 and o_offset=0 immediately, without waiting for a clock edge.
- Alignment: SLIP_CYCLES=64, LOCK_COUNT=8; repeating token 10'b1101010100 serialized so words sit at w[12:3] -> o_offset steps 0,1,2,3, o_locked=1 within 3*64+8+3 cycles, o_ctrl=00, o_de=0.
- Data decode, when locked: feed 10'h100 -> o_de=1, o_data=8'h00; 10'h2FF -> 8'hFE; token 10'b1010101011 -> o_de=0, o_ctrl=11; each output appears 2 cycles after input.
- Lock loss: LOSS_CYCLES=128; LOCKED, then data words only for 128 cycles -> o_locked falls, o_offset increments by 1. 127 data words followed by a token -> stays locked.
- Wrap and tie: start at offset 9 with no tokens -> offset wraps to 0. Lock count reached on the slip-expiry cycle -> LOCKED, offset unchanged.
- i_clk_lock=0 for 1 cycle while LOCKED -> o_locked=0, o_offset=0, outputs 0, hunt restarts.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, symbol widths and the receiver
// alignment state encoding.
package tmds_pkg;

    localparam int unsigned TMDS_W   = 10;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned CTRL_W   = 2;
    localparam int unsigned OFFSET_W = 4;

    localparam logic [TMDS_W-1:0] TOKEN_CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] TOKEN_CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] TOKEN_CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] TOKEN_CTRL_11 = 10'b1010101011;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tmds_state_e;

endpackage

// File: rtl/tmds_decode_word.sv
// Combinational decode of one aligned TMDS symbol: control token detection
// plus the 10->8 transition-minimised data decode.
module tmds_decode_word
    import tmds_pkg::*;
(
    input  logic [TMDS_W-1:0] i_word,
    output logic              o_is_token,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] q;

    always_comb begin
        o_is_token = 1'b1;
        o_ctrl     = '0;
        case (i_word)
            TOKEN_CTRL_00: o_ctrl = 2'b00;
            TOKEN_CTRL_01: o_ctrl = 2'b01;
            TOKEN_CTRL_10: o_ctrl = 2'b10;
            TOKEN_CTRL_11: o_ctrl = 2'b11;
            default:       o_is_token = 1'b0;
        endcase
    end

    // Bit 9 undoes the encoder's inversion, bit 8 selects XOR vs XNOR chaining.
    always_comb begin
        q         = i_word[9] ? ~i_word[DATA_W-1:0] : i_word[DATA_W-1:0];
        o_data    = '0;
        o_data[0] = q[0];
        for (int unsigned i = 1; i < DATA_W; i++) begin
            o_data[i] = i_word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder_dvi_rx.sv
// DVI TMDS receive channel: hunts for the symbol boundary using control
// tokens, then decodes aligned symbols into data/control with display enable.
module tmds_decoder_dvi_rx
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned SLIP_CYCLES = 1024,
    parameter int unsigned LOSS_CYCLES = 4096
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clk_lock,
    input  logic [TMDS_W-1:0]   i_tmds,
    output logic                o_de,
    output logic [DATA_W-1:0]   o_data,
    output logic [CTRL_W-1:0]   o_ctrl,
    output logic                o_locked,
    output logic [OFFSET_W-1:0] o_offset
);

    localparam int unsigned RUN_W  = $clog2(LOCK_COUNT) + 1;
    localparam int unsigned SLIP_W = $clog2(SLIP_CYCLES) + 1;
    localparam int unsigned LOSS_W = $clog2(LOSS_CYCLES) + 1;

    localparam logic [RUN_W-1:0]    RUN_LOCK   = RUN_W'(LOCK_COUNT);
    localparam logic [SLIP_W-1:0]   SLIP_LAST  = SLIP_W'(SLIP_CYCLES - 1);
    localparam logic [LOSS_W-1:0]   LOSS_LAST  = LOSS_W'(LOSS_CYCLES - 1);
    localparam logic [OFFSET_W-1:0] OFFSET_MAX = OFFSET_W'(TMDS_W - 1);

    tmds_state_e         state_q, state_d;
    logic [TMDS_W-1:0]   prev_q, prev_d;
    logic [TMDS_W-1:0]   aw_q, aw_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [SLIP_W-1:0]   slip_q, slip_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic                de_q, de_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                locked_q, locked_d;

    logic [2*TMDS_W-1:0] window;
    logic [OFFSET_W-1:0] offset_inc;
    logic [RUN_W-1:0]    run_inc;
    logic [SLIP_W-1:0]   slip_inc;
    logic [LOSS_W-1:0]   loss_inc;
    logic                dec_is_token;
    logic [CTRL_W-1:0]   dec_ctrl;
    logic [DATA_W-1:0]   dec_data;

    tmds_decode_word u_decode (
        .i_word     (aw_q),
        .o_is_token (dec_is_token),
        .o_ctrl     (dec_ctrl),
        .o_data     (dec_data)
    );

    assign window     = {i_tmds, prev_q};
    assign offset_inc = (offset_q == OFFSET_MAX) ? '0 : offset_q + 1'b1;
    assign run_inc    = dec_is_token ? ((run_q == '1) ? run_q : run_q + 1'b1) : '0;
    assign slip_inc   = (slip_q == '1) ? slip_q : slip_q + 1'b1;
    assign loss_inc   = (loss_q == '1) ? loss_q : loss_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        prev_d   = i_tmds;
        aw_d     = TMDS_W'(window >> offset_q);
        offset_d = offset_q;
        run_d    = run_q;
        slip_d   = slip_q;
        loss_d   = loss_q;
        de_d     = 1'b0;
        data_d   = '0;
        ctrl_d   = '0;
        locked_d = 1'b0;

        case (state_q)
            ST_HUNT: begin
                run_d  = run_inc;
                slip_d = slip_inc;
                // Lock is tested first so a lock on the slip-expiry cycle keeps the offset.
                if (run_inc == RUN_LOCK) begin
                    state_d = ST_LOCKED;
                    slip_d  = '0;
                end else if (slip_q == SLIP_LAST) begin
                    offset_d = offset_inc;
                    run_d    = '0;
                    slip_d   = '0;
                end
            end
            ST_LOCKED: begin
                if (dec_is_token) begin
                    loss_d = '0;
                end else if (loss_q == LOSS_LAST) begin
                    state_d  = ST_HUNT;
                    offset_d = offset_inc;
                    run_d    = '0;
                    slip_d   = '0;
                    loss_d   = '0;
                end else begin
                    loss_d = loss_inc;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // Outputs follow the post-edge state so o_locked moves with the data.
        if (state_d == ST_LOCKED) begin
            locked_d = 1'b1;
            if (dec_is_token) begin
                ctrl_d = dec_ctrl;
            end else begin
                de_d   = 1'b1;
                data_d = dec_data;
                ctrl_d = ctrl_q;
            end
        end

        if (!i_clk_lock) begin
            state_d  = ST_HUNT;
            prev_d   = '0;
            aw_d     = '0;
            offset_d = '0;
            run_d    = '0;
            slip_d   = '0;
            loss_d   = '0;
            de_d     = 1'b0;
            data_d   = '0;
            ctrl_d   = '0;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_HUNT;
            prev_q   <= '0;
            aw_q     <= '0;
            offset_q <= '0;
            run_q    <= '0;
            slip_q   <= '0;
            loss_q   <= '0;
            de_q     <= 1'b0;
            data_q   <= '0;
            ctrl_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            aw_q     <= aw_d;
            offset_q <= offset_d;
            run_q    <= run_d;
            slip_q   <= slip_d;
            loss_q   <= loss_d;
            de_q     <= de_d;
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            locked_q <= locked_d;
        end
    end

    assign o_de     = de_q;
    assign o_data   = data_q;
    assign o_ctrl   = ctrl_q;
    assign o_locked = locked_q;
    assign o_offset = offset_q;

endmodule

// File: tb/tb_tmds_decoder_dvi_rx.sv
// Self-checking bench for tmds_decoder_dvi_rx: symbol streams at chosen bit
// offsets, compared every cycle against a behavioural receiver model.
module tb_tmds_decoder_dvi_rx;

    localparam int LOCK = 8;
    localparam int SLIP = 64;
    localparam int LOSS = 128;

    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK1 = 10'b0010101011;
    localparam logic [9:0] TOK2 = 10'b0101010100;
    localparam logic [9:0] TOK3 = 10'b1010101011;

    logic       clk;
    logic       rst_n;
    logic       clk_lock;
    logic [9:0] tmds;
    logic       o_de;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic       o_locked;
    logic [3:0] o_offset;
    logic [15:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [9:0] m_prev, m_aw;
    logic       m_de, m_locked;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;
    int         m_off, m_run, m_slip, m_loss;
    logic [9:0] last_sym;

    tmds_decoder_dvi_rx #(
        .LOCK_COUNT  (LOCK),
        .SLIP_CYCLES (SLIP),
        .LOSS_CYCLES (LOSS)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clk_lock (clk_lock),
        .i_tmds     (tmds),
        .o_de       (o_de),
        .o_data     (o_data),
        .o_ctrl     (o_ctrl),
        .o_locked   (o_locked),
        .o_offset   (o_offset)
    );

    assign outs = {o_de, o_data, o_ctrl, o_locked, o_offset};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_ctrl(input logic [9:0] x);
        if (x == TOK0) return 0;
        if (x == TOK1) return 1;
        if (x == TOK2) return 2;
        if (x == TOK3) return 3;
        return -1;
    endfunction

    function automatic logic [7:0] ref_data(input logic [9:0] x);
        logic [7:0] q, d;
        q = x[9] ? ~x[7:0] : x[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = x[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    function automatic logic [9:0] rand_data_sym();
        logic [9:0] s;
        s = 10'($urandom);
        while (ref_ctrl(s) >= 0) s = 10'($urandom);
        return s;
    endfunction

    task automatic model_reset();
        m_prev = '0; m_aw = '0; m_de = 0; m_locked = 0; m_data = '0; m_ctrl = '0;
        m_off = 0; m_run = 0; m_slip = 0; m_loss = 0;
    endtask

    task automatic model_step(input logic [9:0] din);
        int c;
        int old_off;
        logic [19:0] win;
        if (!clk_lock) begin
            model_reset();
        end else begin
            c = ref_ctrl(m_aw);
            old_off = m_off;
            if (!m_locked) begin
                m_run = (c >= 0) ? m_run + 1 : 0;
                if (m_run == LOCK) begin
                    m_locked = 1; m_slip = 0;
                end else if (m_slip == SLIP - 1) begin
                    m_off = (m_off + 1) % 10; m_run = 0; m_slip = 0;
                end else begin
                    m_slip++;
                end
            end else begin
                if (c >= 0) m_loss = 0;
                else if (m_loss == LOSS - 1) begin
                    m_locked = 0; m_off = (m_off + 1) % 10;
                    m_run = 0; m_slip = 0; m_loss = 0;
                end else m_loss++;
            end
            if (m_locked) begin
                if (c >= 0) begin
                    m_de = 0; m_data = '0; m_ctrl = 2'(c);
                end else begin
                    m_de = 1; m_data = ref_data(m_aw);
                end
            end else begin
                m_de = 0; m_data = '0; m_ctrl = '0;
            end
            win = {din, m_prev};
            m_aw = 10'(win >> old_off);
            m_prev = din;
        end
    endtask

    task automatic send_word(input logic [9:0] w);
        tmds = w;
        @(posedge clk);
        model_step(w);
        @(negedge clk);
        check("cycle", 32'(outs), 32'({m_de, m_data, m_ctrl, m_locked, 4'(m_off)}));
    endtask

    // Symbol stream whose boundaries sit k bits into each deserialized word.
    task automatic send_sym(input logic [9:0] s, input int k);
        logic [19:0] pair;
        pair = {s, last_sym};
        last_sym = s;
        send_word(10'(pair >> (10 - k)));
    endtask

    task automatic acquire(input int k, input string tag);
        int n;
        int bound;
        bound = k * SLIP + LOCK + 3;
        for (n = 1; n <= bound + 5; n++) begin
            send_sym(TOK0, k);
            if (o_locked) break;
        end
        check({tag, "_locked"}, 32'(o_locked), 1);
        check({tag, "_in_time"}, (n <= bound) ? 1 : 0, 1);
        check({tag, "_offset"}, 32'(o_offset), 32'(k));
        check({tag, "_ctrl_de"}, {o_ctrl, o_de}, 0);
    endtask

    initial begin
        int prev_off;
        bit wrapped;
        clk_lock = 1'b1;
        tmds = '0;
        last_sym = TOK0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #1 check("reset_outs", 32'(outs), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        acquire(3, "align");

        // decode: each symbol's result emerges two sends later
        send_sym(10'h100, 3); send_sym(TOK0, 3);
        check("latency_not_yet", 32'(o_de), 0);
        send_sym(TOK0, 3);
        check("dec_100", {o_de, o_data}, {1'b1, 8'h00});
        send_sym(10'h2FF, 3); send_sym(TOK0, 3); send_sym(TOK0, 3);
        check("dec_2ff", {o_de, o_data}, {1'b1, 8'hFE});
        send_sym(TOK3, 3); send_sym(10'h100, 3); send_sym(10'h100, 3);
        check("tok3", {o_de, o_ctrl}, {1'b0, 2'b11});
        send_sym(TOK0, 3);
        check("ctrl_hold", {o_de, o_ctrl}, {1'b1, 2'b11});
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) == 0) send_sym((i % 2) ? TOK1 : TOK2, 3);
            else send_sym(rand_data_sym(), 3);
        end
        for (int i = 0; i < 4; i++) send_sym(TOK0, 3);

        // asynchronous reset while locked
        check("pre_rst_locked", 32'(o_locked), 1);
        rst_n = 1'b0;
        #1 check("async_rst", 32'(outs), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        acquire(3, "relock_rst");

        // one cycle of upstream lock loss
        clk_lock = 1'b0;
        send_sym(TOK0, 3);
        check("clk_lock_drop", 32'(outs), 0);
        clk_lock = 1'b1;
        acquire(3, "relock_clk");

        // 127 data words then a token keeps lock
        for (int i = 0; i < LOSS - 1; i++) send_sym(rand_data_sym(), 3);
        send_sym(TOK0, 3); send_sym(TOK0, 3); send_sym(TOK0, 3);
        check("no_loss_127", 32'(o_locked), 1);

        // 128 data words drops lock and bumps the offset
        for (int i = 0; i < LOSS; i++) send_sym(rand_data_sym(), 3);
        send_sym(rand_data_sym(), 3);
        check("loss_edge_hold", 32'(o_locked), 1);
        send_sym(rand_data_sym(), 3);
        check("loss_locked", 32'(o_locked), 0);
        check("loss_offset", 32'(o_offset), 4);

        // random words in HUNT until offset wraps 9 -> 0
        wrapped = 0;
        prev_off = int'(o_offset);
        for (int i = 0; i < 1000; i++) begin
            send_word(10'($urandom));
            if (prev_off == 9 && o_offset == 4'd0) begin
                wrapped = 1;
                break;
            end
            prev_off = int'(o_offset);
        end
        check("offset_wrap", 32'(wrapped), 1);

        // lock completes on the very cycle the slip timer expires
        for (int j = 1; j <= SLIP; j++) begin
            send_word((j >= 55 && j <= 62) ? TOK0 : 10'h100);
            if (j == SLIP - 1) check("tie_pre_lock", 32'(o_locked), 0);
        end
        check("tie_locked", 32'(o_locked), 1);
        check("tie_offset", 32'(o_offset), 0);
        for (int i = 0; i < 4; i++) send_word(TOK1);
        check("tie_ctrl", {o_de, o_ctrl}, {1'b0, 2'b01});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
